serial_compare_scheduler: RTL and testbench
===========================================

# serial_compare_scheduler

Shares one MSB-first serial magnitude comparator among `N_REQ` requesters. Each requester offers a pair of `WIDTH`-bit operands. The block does three things:
- arbitrates round-robin between requesters;
- shifts the granted pair into the comparator most-significant bit first, one bit per clock;
- returns a tagged less/equal/greater result on a valid/ready response port.

It sits between parallel-word clients and the bit-serial compare datapath.

## Interface
- `N_REQ`, default 4: number of requesters, ≥1.
- `WIDTH`, default 8: operand width in bits, ≥1.
- `IDW`, default `$clog2(N_REQ)` (min 1): width of the requester index.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_ready` out `N_REQ`: per-requester accept; one-hot or zero.
- `req_a` in `N_REQ*WIDTH`: operand A of requester i, at bits `[i*WIDTH +: WIDTH]`.
- `req_b` in `N_REQ*WIDTH`: operand B, same packing as `req_a`.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out `IDW`: index of the requester the result belongs to.
- `rsp_less`, `rsp_eq`, `rsp_greater` out 1 each: comparison of A against B; exactly one is high while `rsp_valid` is high.
- `busy` out 1: high in SHIFT and RESP.

## Operation
- **FSM states:** IDLE, SHIFT, RESP. The reset state is IDLE.
- **IDLE:**
  - The arbiter searches `req_valid` starting at `rr_ptr` and wrapping modulo `N_REQ`. The first set bit is the grant `g`.
  - `req_ready[g]` is driven combinationally, and only in IDLE.
  - A handshake (`req_valid[g] & req_ready[g]`) loads `req_a[g]` and `req_b[g]` into shift registers, latches `g`, pulses `clear` to the core, loads `bit_cnt = WIDTH-1`, and moves to SHIFT.
  - If no request is valid, the FSM stays in IDLE.
- **SHIFT:**
  - Each cycle the core gets `en=1` and the MSBs of both shift registers; both registers then shift left and `bit_cnt` decrements.
  - When `bit_cnt == 0`, the core's combinational result for the final bit is registered into the result registers, and the FSM moves to RESP.
- **RESP:**
  - `rsp_valid` = 1. `rsp_id` and the three result flags stay stable until `rsp_ready`.
  - On the handshake, `rr_ptr` becomes (latched `g` + 1) mod `N_REQ`, and the FSM returns to IDLE.
- **Requester rules:** `req_valid` may drop before it is granted; this has no effect. Operands are sampled only on the accept edge and may change afterwards.
- **Compare rule:** unsigned magnitude.
  - `eq` stays high while all bits so far are equal.
  - `less` latches on the first differing bit where a=0 and b=1, provided all earlier bits were equal.
  - `greater` = ¬eq & ¬less.
- **N_REQ=1:** arbitration degenerates to a single requester; `rsp_id` is always 0.

## Timing
- **Reset values:** `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_less=0`, `rsp_eq=0`, `rsp_greater=0`, `busy=0`, `rr_ptr=0`. The core is in the state eq=1, less=0.
- **Latency:** accept edge at cycle T → bits presented in cycles T+1..T+WIDTH → `rsp_valid` high from cycle T+WIDTH+1.
- **Throughput:** with `rsp_ready` tied high, accepts are spaced exactly `WIDTH+2` cycles apart (1 IDLE + `WIDTH` SHIFT + 1 RESP).
- **No new accept during a response:** no `req_ready` is asserted while `busy` is high. In particular, `rsp_ready` in RESP does not allow an accept in the same cycle.
- **Reset mid-operation:** asserting `rst` in SHIFT or RESP immediately forces all outputs to their reset values. The in-flight request is dropped and no response is produced. The first request after `rst` falls is served normally.
- **Backpressure:** `rsp_valid` stays high for any number of cycles with `rsp_ready` low. No arbitration occurs meanwhile.

## Structure
- **Package `serial_cmp_pkg`:**
  - `typedef enum logic [1:0] {IDLE, SHIFT, RESP} sched_state_t`
  - `typedef struct packed {logic less, eq, greater;} cmp_result_t`
- **Sub-module `serial_msb_compare_core`:**
  - Ports: `clk`, `rst`, `clear`, `en`, `a`, `b`; outputs `lt`, `eq`, `gt`.
  - Holds the prev-eq and prev-less state and updates it only when `en` is high.
  - `clear` and `rst` both return the state to eq=1, less=0.
- **Top level:** round-robin arbiter, shift registers, bit counter, FSM and result registers.

## Test plan
All scenarios use `WIDTH=8`, `N_REQ=4`.
1. Requester 2 only, A=0x5A, B=0x5B, accepted at T → `rsp_valid` at T+9 with `rsp_id=2`, `rsp_less=1`.
2. A=0x80, B=0x7F → greater (decided on the MSB). A=B=0xC3 → eq=1. A=0x00, B=0xFF → less. A=B=0x00 → eq.
3. All four `req_valid` high from reset and held → grants in order 0, 1, 2, 3, 0. Then with only 0 and 3 valid and `rr_ptr=1` → grant 3, then 0.
4. `rsp_ready` held low for 5 cycles in RESP → `rsp_valid` and result remain stable, no `req_ready`. On `rsp_ready` → return to IDLE the next cycle.
5. Async `rst` pulse during the 4th SHIFT bit → `busy=0` and `rsp_valid=0` immediately, no response emitted. A new request (A=0x01, B=0x02) then completes with less=1 in 9 cycles.
6. Continuous requests with `rsp_ready` tied high → accept edges exactly 10 cycles apart and one-hot `req_ready`.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial compare scheduler: FSM states and the
// registered less/equal/greater result.
package serial_cmp_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} sched_state_t;

    typedef struct packed {
        logic less;
        logic eq;
        logic greater;
    } cmp_result_t;

endpackage

// File: rtl/serial_msb_compare_core.sv
// MSB-first bit-serial unsigned magnitude comparator. Outputs reflect the
// result including the bit currently presented when en is high.
module serial_msb_compare_core (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic lt,
    output logic eq,
    output logic gt
);

    logic eq_q, less_q;
    logic eq_d, less_d;

    always_comb begin
        eq_d   = eq_q;
        less_d = less_q;
        if (en) begin
            less_d = less_q | (eq_q & ~a & b);
            eq_d   = eq_q & (a ~^ b);
        end
    end

    assign lt = less_d;
    assign eq = eq_d;
    assign gt = ~eq_d & ~less_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_q   <= 1'b1;
            less_q <= 1'b0;
        end else if (clear) begin
            eq_q   <= 1'b1;
            less_q <= 1'b0;
        end else if (en) begin
            eq_q   <= eq_d;
            less_q <= less_d;
        end
    end

endmodule

// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler sharing one serial MSB-first comparator among
// N_REQ requesters, with a tagged valid/ready result port.
module serial_compare_scheduler
    import serial_cmp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_less,
    output logic                   rsp_eq,
    output logic                   rsp_greater,
    output logic                   busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sched_state_t   state, state_n;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0]  bit_cnt;
    logic [IDW-1:0] id_q, rr_ptr;
    logic [IDW-1:0] grant_idx, cand;
    logic           grant_found;
    logic           accept;
    logic           shift_en;
    cmp_result_t    res_q;
    logic           core_lt, core_eq, core_gt;

    // Search req_valid starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                // rst gates ready so outputs read as reset values while held
                if (grant_found && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_n              = SHIFT;
                end
            end
            SHIFT: if (bit_cnt == '0) state_n = RESP;
            RESP:  if (rsp_ready)     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign shift_en = (state == SHIFT);

    serial_msb_compare_core u_core (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (shift_en),
        .a     (a_sh[WIDTH-1]),
        .b     (b_sh[WIDTH-1]),
        .lt    (core_lt),
        .eq    (core_eq),
        .gt    (core_gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            bit_cnt <= '0;
            id_q    <= '0;
            rr_ptr  <= '0;
            res_q   <= '0;
        end else begin
            if (accept) begin
                a_sh    <= req_a[grant_idx*WIDTH +: WIDTH];
                b_sh    <= req_b[grant_idx*WIDTH +: WIDTH];
                id_q    <= grant_idx;
                bit_cnt <= CW'(WIDTH - 1);
            end
            if (shift_en) begin
                a_sh    <= a_sh << 1;
                b_sh    <= b_sh << 1;
                bit_cnt <= bit_cnt - 1'b1;
                if (bit_cnt == '0) begin
                    res_q.less    <= core_lt;
                    res_q.eq      <= core_eq;
                    res_q.greater <= core_gt;
                end
            end
            if (state == RESP && rsp_ready) begin
                rr_ptr <= (32'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
            end
        end
    end

    assign rsp_valid   = (state == RESP);
    assign busy        = (state != IDLE);
    assign rsp_id      = id_q;
    assign rsp_less    = res_q.less;
    assign rsp_eq      = res_q.eq;
    assign rsp_greater = res_q.greater;

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Self-checking bench for serial_compare_scheduler (N_REQ=4, WIDTH=8):
// directed vector table, hand-written corner sequences, randomized model run.
module tb_serial_compare_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic           rsp_less, rsp_eq, rsp_greater, busy;

    always #5 clk = ~clk;

    serial_compare_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_less    (rsp_less),
        .rsp_eq      (rsp_eq),
        .rsp_greater (rsp_greater),
        .busy        (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b);
        return {a < b, a == b, a > b};
    endfunction

    function automatic int arb(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Behavioural model state: transaction-level view of the scheduler
    int          m_ptr, m_g, m_shift, cyc;
    bit          m_idle, m_resp;
    logic [7:0]  m_a, m_b;
    int          grants[$];
    int          acc_cyc[$];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; m_idle = 1; m_resp = 0; m_shift = 0; cyc = 0;
        grants.delete(); acc_cyc.delete();
    endtask

    // One request from a single requester; returns cycles from the accept
    // cycle to the first rsp_valid cycle, and leaves the DUT in RESP.
    task automatic do_txn(input int id, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [1:0] gid, output logic [2:0] res);
        int w;
        @(negedge clk);
        req_valid = '0; req_valid[id] = 1'b1;
        req_a[id*W +: W] = a; req_b[id*W +: W] = b;
        rsp_ready = 1'b0;
        #1;
        w = 0;
        while (!req_ready[id] && w < 20) begin @(negedge clk); #1; w++; end
        check("txn_grant_in_time", 32'(w < 20), 1);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = '0; req_a = $urandom; req_b = $urandom;
            #1;
            lat++;
        end while (!rsp_valid && lat < 30);
        gid = rsp_id;
        res = {rsp_less, rsp_eq, rsp_greater};
    endtask

    task automatic ack();
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
        #1;
        check("ack_idle", {30'd0, rsp_valid, busy}, 0);
    endtask

    task automatic step(input logic [3:0] v, input logic rr);
        logic [3:0] exp_ready;
        logic [7:0] a;
        int g;
        @(negedge clk);
        req_valid = v; rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            a = 8'($urandom);
            req_a[i*W +: W] = a;
            req_b[i*W +: W] = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
        end
        #1;
        cyc++;
        exp_ready = '0;
        g = -1;
        if (m_idle) begin
            g = arb(v, m_ptr);
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        check("model_req_ready", 32'(req_ready), 32'(exp_ready));
        check("model_rsp_valid", 32'(rsp_valid), 32'(m_resp));
        check("model_busy", 32'(busy), 32'(!m_idle));
        if (m_resp) begin
            check("model_rsp_id", 32'(rsp_id), m_g);
            check("model_rsp_flags", {29'd0, rsp_less, rsp_eq, rsp_greater}, 32'(ref_cmp(m_a, m_b)));
        end
        if (m_idle) begin
            if (g >= 0) begin
                m_g = g; m_a = req_a[g*W +: W]; m_b = req_b[g*W +: W];
                m_idle = 0; m_shift = W;
                grants.push_back(g); acc_cyc.push_back(cyc);
            end
        end else if (!m_resp) begin
            m_shift--;
            if (m_shift == 0) m_resp = 1;
        end else if (rr) begin
            m_resp = 0; m_idle = 1; m_ptr = (m_g + 1) % N;
        end
    endtask

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] exp;  // {less, eq, greater}
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat, n, miss, exp_g[7];
        logic [1:0] gid;
        logic [2:0] res;

        vecs[0] = '{2, 8'h5A, 8'h5B, 3'b100};
        vecs[1] = '{1, 8'h80, 8'h7F, 3'b001};
        vecs[2] = '{3, 8'hC3, 8'hC3, 3'b010};
        vecs[3] = '{0, 8'h00, 8'hFF, 3'b100};
        vecs[4] = '{2, 8'h00, 8'h00, 3'b010};
        vecs[5] = '{1, 8'hFF, 8'hFE, 3'b001};
        vecs[6] = '{0, 8'hFF, 8'hFF, 3'b010};
        exp_g   = '{0, 1, 2, 3, 0, 3, 0};

        // Reset values, with requests pending to show ready is held off
        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1; req_a = '0; req_b = '0;
        #2;
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp", {27'd0, rsp_valid, rsp_id, rsp_less, rsp_eq}, 0);
        check("reset_greater_busy", {30'd0, rsp_greater, busy}, 0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].id, vecs[i].a, vecs[i].b, lat, gid, res);
            check($sformatf("vec%0d_latency", i), lat, 9);
            check($sformatf("vec%0d_rsp_id", i), 32'(gid), vecs[i].id);
            check($sformatf("vec%0d_flags", i), 32'(res), 32'(vecs[i].exp));
            ack();
        end

        // Backpressure: result held, no arbitration while rsp_ready is low
        do_txn(1, 8'h3C, 8'h3D, lat, gid, res);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); req_valid = 4'hF; #1;
            check("bp_hold", {25'd0, rsp_valid, busy, req_ready, rsp_id, rsp_less},
                  {25'd0, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b1});
            check("bp_flags", {30'd0, rsp_eq, rsp_greater}, 0);
        end
        @(negedge clk); rsp_ready = 1'b1; #1;
        check("bp_no_accept_in_resp", 32'(req_ready), 0);
        @(negedge clk); rsp_ready = 1'b0; req_valid = '0; #1;
        check("bp_release", {30'd0, rsp_valid, busy}, 0);

        // Async reset during the 4th shift bit drops the request
        @(negedge clk);
        req_valid = 4'b0100; req_a[2*W +: W] = 8'h10; req_b[2*W +: W] = 8'h20;
        #1;
        n = 0;
        while (!req_ready[2] && n < 20) begin @(negedge clk); #1; n++; end
        check("rst_txn_grant", 32'(n < 20), 1);
        for (int i = 0; i < 4; i++) begin @(negedge clk); req_valid = '0; end
        #1;
        check("rst_mid_shift_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {27'd0, busy, rsp_valid, rsp_less, rsp_eq, rsp_greater}, 0);
        @(negedge clk); rst = 1'b0;
        miss = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); #1; if (rsp_valid || busy) miss++; end
        check("rst_no_response", miss, 0);
        do_txn(0, 8'h01, 8'h02, lat, gid, res);
        check("post_rst_latency", lat, 9);
        check("post_rst_result", {29'd0, res}, {29'd0, 3'b100});
        ack();

        // Model-driven: all four valid from reset, then only 0 and 3
        do_reset();
        n = 0;
        while (grants.size() < 5 && n < 100) begin step(4'hF, 1'b1); n++; end
        while (grants.size() < 7 && n < 200) begin step(4'b1001, 1'b1); n++; end
        check("rr_grant_count", grants.size(), 7);
        for (int i = 0; i < 7 && i < grants.size(); i++)
            check($sformatf("rr_grant%0d", i), grants[i], exp_g[i]);
        for (int i = 1; i < acc_cyc.size(); i++)
            check($sformatf("accept_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], W + 2);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
